// File: rtl/uart_cmd_parser_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser_pkg
// Shared constants, FSM state encoding and the frame checksum helper for the
// UART command parser and its register file.
// ---------------------------------------------------------------------------
package uart_cmd_parser_pkg;

  localparam logic [7:0] SYNC   = 8'h55;
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  localparam int NUM_REGS = 4;
  localparam int REG_AW   = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_CMD  = 3'd1,
    GET_ADDR = 3'd2,
    GET_DATA = 3'd3,
    GET_CHK  = 3'd4,
    EXEC     = 3'd5,
    TX       = 3'd6,
    TX_WAIT  = 3'd7
  } state_t;

  // Frame checksum: XOR of CMD, ADDR and DATA.
  function automatic logic [7:0] calc_chk(input logic [7:0] cmd,
                                          input logic [7:0] addr,
                                          input logic [7:0] data);
    return cmd ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_cmd_regfile.sv
// ---------------------------------------------------------------------------
// uart_cmd_regfile
// NUM_REGS x 8-bit register file: one synchronous write port, one
// combinational read port, asynchronous active-high reset to zero.
// Ports:
//   clk, rst   - clock, async active-high reset
//   we         - write enable (writes wdata to regs[waddr] on rising edge)
//   waddr      - write address
//   wdata      - write data
//   raddr      - read address
//   rdata      - combinational read data regs[raddr]
//   regs_flat  - all registers, reg0 in [7:0] upward
// ---------------------------------------------------------------------------
module uart_cmd_regfile
  import uart_cmd_parser_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [REG_AW-1:0]       waddr,
  input  logic [7:0]              wdata,
  input  logic [REG_AW-1:0]       raddr,
  output logic [7:0]              rdata,
  output logic [NUM_REGS*8-1:0]   regs_flat
);

  logic [NUM_REGS-1:0][7:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata     = regs_q[raddr];
  assign regs_flat = regs_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
// Parses 5-byte frames (SYNC, CMD, ADDR, DATA, CHK) arriving from a UART
// receiver, executes register writes/reads and sends a one-byte response
// (ACK, read data, or NAK) back through a UART transmitter.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is no
// back-pressure, so bytes arriving while a response is pending are dropped
// and counted. tx_start is a one-cycle request issued only while tx_busy=0;
// tx_data is held from tx_start until the parser returns to IDLE.
//
// Ports:
//   clk, rst  - clock, async active-high reset
//   rx_valid  - received-byte strobe
//   rx_data   - received byte
//   tx_start  - transmit request strobe
//   tx_data   - byte to transmit
//   tx_busy   - transmitter busy
//   regs      - flattened register file, reg0 in [7:0] .. reg3 in [31:24]
//   frame_ok  - strobe on each accepted valid frame
//   err_cnt   - saturating count of rejected frames, timeouts, dropped bytes
// ---------------------------------------------------------------------------
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 240000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [31:0] regs,
  output logic        frame_ok,
  output logic [7:0]  err_cnt
);

  localparam int               TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

  state_t          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      chk_q, chk_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      err_q, err_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            wait_first_q, wait_first_d;

  logic            in_get;
  logic            timeout_hit;
  logic            frame_valid;
  logic            rf_we;
  logic [7:0]      rf_rdata;
  logic [1:0]      err_inc;
  logic [8:0]      err_sum;

  assign in_get      = (state_q == GET_CMD) || (state_q == GET_ADDR) ||
                       (state_q == GET_DATA) || (state_q == GET_CHK);
  // Expiry takes priority over a byte arriving in the same cycle.
  assign timeout_hit = in_get && (to_q == TO_LAST);
  assign frame_valid = (chk_q == calc_chk(cmd_q, addr_q, data_q)) &&
                       ((cmd_q == CMD_WR) || (cmd_q == CMD_RD)) &&
                       (int'(addr_q) < NUM_REGS);

  uart_cmd_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (rf_we),
    .waddr     (addr_q[REG_AW-1:0]),
    .wdata     (data_q),
    .raddr     (addr_q[REG_AW-1:0]),
    .rdata     (rf_rdata),
    .regs_flat (regs)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    data_d       = data_q;
    chk_d        = chk_q;
    tx_data_d    = tx_data_q;
    to_d         = '0;
    wait_first_d = 1'b0;
    tx_start     = 1'b0;
    frame_ok     = 1'b0;
    rf_we        = 1'b0;
    err_inc      = 2'd0;

    case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC)) begin
          state_d = GET_CMD;
        end
      end
      GET_CMD: begin
        if (timeout_hit) begin
          state_d = IDLE;
          err_inc = 2'd1;
        end else if (rx_valid) begin
          cmd_d   = rx_data;
          state_d = GET_ADDR;
        end else begin
          to_d = to_q + TO_ONE;
        end
      end
      GET_ADDR: begin
        if (timeout_hit) begin
          state_d = IDLE;
          err_inc = 2'd1;
        end else if (rx_valid) begin
          addr_d  = rx_data;
          state_d = GET_DATA;
        end else begin
          to_d = to_q + TO_ONE;
        end
      end
      GET_DATA: begin
        if (timeout_hit) begin
          state_d = IDLE;
          err_inc = 2'd1;
        end else if (rx_valid) begin
          data_d  = rx_data;
          state_d = GET_CHK;
        end else begin
          to_d = to_q + TO_ONE;
        end
      end
      GET_CHK: begin
        if (timeout_hit) begin
          state_d = IDLE;
          err_inc = 2'd1;
        end else if (rx_valid) begin
          chk_d   = rx_data;
          state_d = EXEC;
        end else begin
          to_d = to_q + TO_ONE;
        end
      end
      EXEC: begin
        frame_ok = frame_valid;
        rf_we    = frame_valid && (cmd_q == CMD_WR);
        if (!frame_valid) begin
          tx_data_d = NAK;
          err_inc   = 2'd1;
        end else if (cmd_q == CMD_WR) begin
          tx_data_d = ACK;
        end else begin
          // Read data is sampled before any write could land this cycle.
          tx_data_d = rf_rdata;
        end
        state_d = TX;
      end
      TX: begin
        if (!tx_busy) begin
          tx_start     = 1'b1;
          wait_first_d = 1'b1;
          state_d      = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // The UART may need a cycle to raise tx_busy after tx_start, so the
        // first cycle here does not look at it.
        if (!wait_first_q && !tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // No buffering while a response is in flight: incoming bytes are lost.
    if (rx_valid && ((state_q == EXEC) || (state_q == TX) || (state_q == TX_WAIT))) begin
      err_inc = err_inc + 2'd1;
    end

    err_sum = {1'b0, err_q} + {7'b0, err_inc};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      chk_q        <= '0;
      tx_data_q    <= '0;
      err_q        <= '0;
      to_q         <= '0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      chk_q        <= chk_d;
      tx_data_q    <= tx_data_d;
      err_q        <= err_d;
      to_q         <= to_d;
      wait_first_q <= wait_first_d;
    end
  end

  assign tx_data = tx_data_q;
  assign err_cnt = err_q;

endmodule
